// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / EXT) arbiter for a single byte-wide memory port with CPU burst reads.
// Optional wait-cycle statistics are compiled in with MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MEM_LAT   = 1,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_burst,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_adr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [15:0]   cpu_wait_cnt,
  output logic [15:0]   ext_wait_cnt,
`endif
  output logic [1:0]    state_dbg
);

  // Handshake: a requester holds req (and its command fields) high until it
  // sees a one-cycle gnt; the command is latched when sampled in IDLE, so
  // inputs may change freely after gnt. Each read beat comes back as exactly
  // one rvalid pulse, MEM_LAT cycles after its mem_re, on the owner's side only.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BURST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0]    state;
  logic          own_cpu;
  logic          last_cpu;
  logic [BW-1:0] beat;
  logic [AW-1:0] lat_adr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic          lat_burst;

  logic          issuing;
  logic          last_beat;
  logic          sel_cpu;

  logic [MEM_LAT-1:0] pv;
  logic [MEM_LAT-1:0] pown;
  logic [MEM_LAT-1:0] plast;

  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  assign issuing   = (state == S_ISSUE);
  assign last_beat = (beat == (lat_burst ? LAST_BURST_BEAT : '0));
  // On a tie the side that did not own the previous transaction wins.
  assign sel_cpu   = cpu_req && (!ext_req || !last_cpu);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      own_cpu   <= 1'b0;
      last_cpu  <= 1'b0;
      beat      <= '0;
      lat_adr   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_burst <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || ext_req) begin
            own_cpu   <= sel_cpu;
            last_cpu  <= sel_cpu;
            lat_adr   <= sel_cpu ? cpu_adr : ext_adr;
            lat_we    <= sel_cpu ? cpu_we : ext_we;
            lat_wdata <= sel_cpu ? cpu_wdata : ext_wdata;
            lat_burst <= sel_cpu && cpu_burst && !cpu_we;
            beat      <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last_beat) begin
            beat  <= '0;
            state <= lat_we ? S_IDLE : S_DRAIN;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        S_DRAIN: begin
          if (pv[MEM_LAT-1] && plast[MEM_LAT-1]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return delay line, tagged with owner and last-beat flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv    <= '0;
      pown  <= '0;
      plast <= '0;
    end else begin
      pv[0]    <= issuing && !lat_we;
      pown[0]  <= own_cpu;
      plast[0] <= last_beat;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv[i]    <= pv[i-1];
        pown[i]  <= pown[i-1];
        plast[i] <= plast[i-1];
      end
    end
  end

  assign cpu_gnt    = issuing && (beat == '0) && own_cpu;
  assign ext_gnt    = issuing && (beat == '0) && !own_cpu;
  assign mem_re     = issuing && !lat_we;
  assign mem_we     = issuing && lat_we;
  assign mem_adr    = issuing ? (lat_adr + AW'(beat)) : '0;
  assign mem_wdata  = mem_we ? lat_wdata : '0;

  assign cpu_rvalid = pv[MEM_LAT-1] && pown[MEM_LAT-1];
  assign ext_rvalid = pv[MEM_LAT-1] && !pown[MEM_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ext_rvalid) ext_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = ext_rvalid ? mem_rdata : ext_rdata_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_wait_cnt <= '0;
      ext_wait_cnt <= '0;
    end else begin
      if (cpu_req && !cpu_gnt && (cpu_wait_cnt != 16'hFFFF)) cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      if (ext_req && !ext_gnt && (ext_wait_cnt != 16'hFFFF)) ext_wait_cnt <= ext_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory port between two requesters.
- CPU side: the multicycle controller/datapath, which does 4-byte instruction fetch bursts plus byte load/store.
- EXT side: a loader/debug port that fills and inspects program memory.
- Sequences burst beats, pipelines reads against fixed memory latency, arbitrates round-robin, and routes read data back to the owner.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from mem_re to valid mem_rdata (legal 1..3).
- BURST_LEN, 4, beats in a CPU burst read (instruction fetch).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU transaction request; held high until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_burst  in  1  1 = BURST_LEN-beat read; ignored when cpu_we = 1.
- cpu_adr  in  AW  start address.
- cpu_wdata  in  DW  write byte.
- cpu_gnt  out  1  one-cycle pulse: request captured.
- cpu_rvalid  out  1  one pulse per returned read beat.
- cpu_rdata  out  DW  read byte; valid when cpu_rvalid = 1.
- ext_req, ext_we, ext_adr, ext_wdata  in  1/1/AW/DW  same meaning as the CPU side; single-beat only.
- ext_gnt, ext_rvalid, ext_rdata  out  1/1/DW  same meaning as the CPU side.
- mem_re  out  1  memory read strobe, one per beat.
- mem_we  out  1  memory write strobe.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_re.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_owner = EXT, beat counter = 0, rvalid delay line cleared.
  - All outputs 0 (gnt, rvalid, mem_re, mem_we, mem_adr, mem_wdata, rdata).
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - req sampled at the clock edge.
  - One req high: that requester wins.
  - Both high: the requester that is not last_owner wins, so CPU wins the first tie after reset.
  - Winner's adr, we, wdata and effective burst (cpu_burst & ~cpu_we; 0 for EXT) are latched; owner and last_owner updated; go to ISSUE.
- ISSUE:
  - First ISSUE cycle: owner's gnt high for exactly 1 cycle.
  - Each ISSUE cycle drives one beat: mem_adr = latched adr + beat (mod 2^AW, wraps 0xFF to 0x00 at AW = 8), and mem_re = ~we or mem_we = we.
  - Beats are issued on consecutive cycles: 1 beat, or BURST_LEN beats when burst.
  - After the last beat: writes go to IDLE; reads go to DRAIN.
- DRAIN:
  - Wait until the last beat's rvalid has been emitted, then go to IDLE.
- Read return:
  - rvalid delay line of depth MEM_LAT tagged with owner.
  - Owner's rvalid high exactly MEM_LAT cycles after each mem_re.
  - rdata = mem_rdata during rvalid; holds its last value otherwise.
  - Non-owner rvalid is never asserted.
- Latency: req high at edge N → gnt and beat 0 in cycle N+1 → first rvalid at N+1+MEM_LAT → burst last rvalid at N+BURST_LEN+MEM_LAT.
- Turnaround: at least 1 IDLE cycle between transactions.
- Writes: mem_we, mem_adr and mem_wdata are valid for 1 cycle. Write completion is signalled only by gnt.
- req asserted while busy: not captured; must stay high until gnt. A req dropped before gnt is simply never served.
- Inputs changing after gnt do not affect the transaction in flight.
- Reset mid-transaction: aborts immediately; pending rvalids are discarded and never appear after reset release.
- mem_re and mem_we are never high in the same cycle.

Optional Feature:
- Macro MEM_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs cpu_wait_cnt[15:0] and ext_wait_cnt[15:0].
  - Each increments every cycle its req = 1 and it is not being granted; saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- CPU burst read: cpu_adr = 0x10, cpu_burst = 1, MEM_LAT = 1 → cpu_gnt 1 cycle later; mem_adr 0x10..0x13 on 4 consecutive cycles; 4 cpu_rvalid pulses with matching bytes; then IDLE.
- EXT write then read: write 0xA5 to 0x20, then read 0x20 → mem_we single cycle with 0x20/0xA5; ext_rdata = 0xA5 at ext_rvalid; cpu_rvalid stays 0.
- Simultaneous req from both sides, repeated: after reset, grant order is CPU, EXT, CPU, EXT; every transaction completes before the next gnt.
- Burst wrap: cpu_adr = 0xFE, burst → mem_adr 0xFE, 0xFF, 0x00, 0x01.
- rst pulled low during beat 2 of a burst with MEM_LAT = 3 → all outputs 0 asynchronously; no rvalid after release; next cpu_req is served normally.
- With MEM_PORT_ARBITER_STATS_EN: hold ext_req during a CPU burst (MEM_LAT = 1) → ext_wait_cnt = 6 at ext_gnt.
